adder_pipe_chain: RTL and testbench

ADDER_PIPE_CHAIN -- requirements
Module: adder_pipe_chain

---
 rtl/adder_pipe_chain.sv | 94 +++++++++
 tb/tb_adder_pipe_chain.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : adder_pipe_chain
// Description : Elastic chain of DEPTH valid/ready stages. Each stage adds a
//               constant INC to the word passing through it, either wrapping
//               modulo 2^WIDTH or saturating at 2^WIDTH-1 (sat_mode). Ready
//               propagates backwards so that an emptied stage accepts a new
//               word in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_pipe_chain #(
    parameter int          WIDTH = 8,
    parameter int          DEPTH = 2,
    parameter int unsigned INC   = 1
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       sat_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int             c_occ_w = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] c_inc = WIDTH'(INC);

    // Per-stage registered state
    logic             r_valid [DEPTH];
    logic [WIDTH-1:0] r_data  [DEPTH];

    // Per-stage combinational view: ready chain, source word, adder result
    logic             w_ready     [DEPTH+1];
    logic             w_src_valid [DEPTH];
    logic [WIDTH-1:0] w_src_data  [DEPTH];
    logic [WIDTH:0]   w_sum       [DEPTH];
    logic [WIDTH-1:0] w_next      [DEPTH];

    // The downstream consumer terminates the ready chain
    assign w_ready[DEPTH] = out_ready;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k = k + 1) begin : g_stage
            // Stage 0 is fed by the block input, later stages by their predecessor
            if (k == 0) begin : g_src_input
                assign w_src_valid[k] = in_valid;
                assign w_src_data[k]  = in_data;
            end else begin : g_src_stage
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_data[k]  = r_data[k-1];
            end

            // A stage can take a word if it is empty or its word moves on now;
            // depends only on registered state and out_ready, never on in_valid
            assign w_ready[k] = !r_valid[k] || w_ready[k+1];

            // One extra bit captures the carry used to detect overflow
            assign w_sum[k]  = {1'b0, w_src_data[k]} + {1'b0, c_inc};
            assign w_next[k] = (sat_mode && w_sum[k][WIDTH]) ? {WIDTH{1'b1}}
                                                             : w_sum[k][WIDTH-1:0];

            // Load on transfer, drain to empty when ready without a source, hold when stalled
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end else if (w_ready[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_next[k];
                    end
                end
            end
        end
    endgenerate

    // Occupancy is the number of stages currently holding a word
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + c_occ_w'(r_valid[i]);
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_pipe_chain
// Description : Directed self-checking bench for adder_pipe_chain; a default
//               instance (WIDTH=8, DEPTH=2, INC=1) and a DEPTH=5, INC=3 one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_pipe_chain;

    logic       clock;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sat_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    logic       in_valid5;
    logic       in_ready5;
    logic [7:0] in_data5;
    logic       out_valid5;
    logic       out_ready5;
    logic [7:0] out_data5;
    logic [2:0] occupancy5;

    int n_vec;
    int n_bad;

    adder_pipe_chain #(.WIDTH(8), .DEPTH(2), .INC(1)) u_dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sat_mode  (sat_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    adder_pipe_chain #(.WIDTH(8), .DEPTH(5), .INC(3)) u_dut5 (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_data   (in_data5),
        .sat_mode  (1'b0),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_data  (out_data5),
        .occupancy (occupancy5)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        sat_mode  = 1'b0;
        out_ready = 1'b1;
        in_valid5 = 1'b0;
        in_data5  = 8'h00;
        out_ready5 = 1'b1;

        // Reset state, observed before any clock edge
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clock);
        rst_n = 1'b1;

        // Latency: 0x05 -> 0x07 two edges later
        in_valid = 1'b1; in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        check("lat_valid_c1", 32'(out_valid), 32'd0);
        check("lat_occ_c1",   32'(occupancy), 32'd1);
        tick();
        check("lat_valid_c2", 32'(out_valid), 32'd1);
        check("lat_data_c2",  32'(out_data),  32'h07);
        tick();
        check("lat_drained",  32'(out_valid), 32'd0);

        // Wrap: 0xFF -> 0x00 -> 0x01
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        check("wrap_data", 32'(out_data), 32'h01);
        tick();

        // Saturate: 0xFF stays 0xFF; 0xFE -> 0xFF -> 0xFF
        sat_mode = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        check("sat_ff", 32'(out_data), 32'hFF);
        in_valid = 1'b1; in_data = 8'hFE;
        tick();
        in_valid = 1'b0;
        tick();
        check("sat_fe", 32'(out_data), 32'hFF);
        tick();
        sat_mode = 1'b0;

        // Backpressure: two of three words accepted while stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h10;
        tick();
        in_data = 8'h20;
        tick();
        in_data = 8'h30;
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_occupancy", 32'(occupancy), 32'd2);
        check("bp_out_data",  32'(out_data),  32'h12);
        tick();
        check("bp_hold_data",  32'(out_data),  32'h12);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_rdy",   32'(in_ready),  32'd0);
        // Release: push of 0x30 and pop of 0x12 in the same cycle
        out_ready = 1'b1;
        #1;
        check("bp_full_rdy", 32'(in_ready), 32'd1);
        check("bp_pop0",     32'(out_data), 32'h12);
        tick();
        in_valid = 1'b0;
        check("bp_pop1_v", 32'(out_valid), 32'd1);
        check("bp_pop1",   32'(out_data),  32'h22);
        tick();
        check("bp_pop2_v", 32'(out_valid), 32'd1);
        check("bp_pop2",   32'(out_data),  32'h32);
        tick();
        check("bp_empty",  32'(out_valid), 32'd0);

        // Streaming: 0..7 in back to back, 2..9 out back to back
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            in_data  = 8'(c);
            tick();
            if (c >= 1 && c <= 8) begin
                check($sformatf("str_v%0d", c), 32'(out_valid), 32'd1);
                check($sformatf("str_d%0d", c), 32'(out_data),  32'(c + 1));
            end else begin
                check($sformatf("str_v%0d", c), 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;

        // Reset mid-flight: fill, then assert reset between edges
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h50;
        tick();
        in_data = 8'h60;
        tick();
        in_valid = 1'b0;
        check("mr_full", 32'(occupancy), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_occupancy", 32'(occupancy), 32'd0);
        check("mr_out_data",  32'(out_data),  32'h00);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        @(negedge clock);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h40;
        tick();
        in_valid = 1'b0;
        check("mr_first_acc", 32'(occupancy), 32'd1);
        tick();
        check("mr_v",   32'(out_valid), 32'd1);
        check("mr_d",   32'(out_data),  32'h42);
        tick();
        check("mr_only", 32'(out_valid), 32'd0);

        // DEPTH=5, INC=3: 0x00 -> 0x0F five edges later
        in_valid5 = 1'b1; in_data5 = 8'h00;
        tick();
        in_valid5 = 1'b0;
        tick();
        tick();
        tick();
        check("p5_v_c4", 32'(out_valid5), 32'd0);
        tick();
        check("p5_v_c5", 32'(out_valid5), 32'd1);
        check("p5_d_c5", 32'(out_data5),  32'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
